// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues lw/lb/lbu/sw/sb over a req/ack bus and
// forwards load data and exception codes to writeback. Define MEM_TIMEOUT_EN to add a bus-error timeout.
`ifndef TRAP_OVERFLOW
`define TRAP_OVERFLOW  8'h01
`endif
`ifndef TRAP_UNALIGNED
`define TRAP_UNALIGNED 8'h04
`endif
`ifndef TRAP_BUSERR
`define TRAP_BUSERR    8'h05
`endif
`ifndef TRAP_STALL
`define TRAP_STALL     8'hFF
`endif

module mem_access #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  mem_op,
  input  logic [31:0] alu_val,
  input  logic [31:0] store_val,
  input  logic [7:0]  exception_in,
  output logic [31:0] out_val,
  output logic [7:0]  exception,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LW   = 3'd1;
  localparam logic [2:0] OP_LB   = 3'd2;
  localparam logic [2:0] OP_LBU  = 3'd3;
  localparam logic [2:0] OP_SW   = 3'd4;
  localparam logic [2:0] OP_SB   = 3'd5;

  state_t      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] out_val_q, out_val_d;
  logic [7:0]  exception_q, exception_d;
  logic        stall_q, stall_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  logic [7:0]  rd_byte;
  logic [31:0] load_val;

  // Byte n of the bus lives in lane mem_rdata[8n+7:8n].
  always_comb begin
    rd_byte = mem_rdata[8*off_q +: 8];
    case (op_q)
      OP_LW:   load_val = mem_rdata;
      OP_LB:   load_val = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_val = {24'd0, rd_byte};
      default: load_val = 32'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    off_d       = off_q;
    out_val_d   = out_val_q;
    exception_d = exception_q;
    stall_d     = stall_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        stall_d   = 1'b0;
        mem_req_d = 1'b0;
        if (exception_in != 8'd0) begin
          exception_d = exception_in;
          out_val_d   = 32'd0;
        end else begin
          case (mem_op)
            OP_NONE: begin
              out_val_d   = alu_val;
              exception_d = 8'd0;
            end
            OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB: begin
              if ((mem_op == OP_LW || mem_op == OP_SW) && alu_val[1:0] != 2'b00) begin
                exception_d = `TRAP_UNALIGNED;
                out_val_d   = 32'd0;
              end else begin
                mem_req_d   = 1'b1;
                mem_addr_d  = {alu_val[31:2], 2'b00};
                mem_we_d    = (mem_op == OP_SW) || (mem_op == OP_SB);
                mem_be_d    = (mem_op == OP_LW || mem_op == OP_SW) ? 4'b1111
                                                                   : (4'b0001 << alu_val[1:0]);
                mem_wdata_d = (mem_op == OP_SB) ? {4{store_val[7:0]}} : store_val;
                stall_d     = 1'b1;
                exception_d = `TRAP_STALL;
                op_d        = mem_op;
                off_d       = alu_val[1:0];
                state_d     = BUSY;
`ifdef MEM_TIMEOUT_EN
                cnt_d       = '0;
`endif
              end
            end
            default: begin
              exception_d = `TRAP_STALL;
              out_val_d   = 32'd0;
            end
          endcase
        end
      end
      BUSY: begin
        stall_d     = 1'b1;
        exception_d = `TRAP_STALL;
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          stall_d     = 1'b0;
          exception_d = 8'd0;
          out_val_d   = load_val;
          state_d     = IDLE;
        end
`ifdef MEM_TIMEOUT_EN
        // A same-cycle ack wins over the timeout because it is tested first.
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          stall_d     = 1'b0;
          exception_d = `TRAP_BUSERR;
          out_val_d   = 32'd0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= OP_NONE;
      off_q       <= 2'd0;
      out_val_q   <= 32'd0;
      exception_q <= `TRAP_STALL;
      stall_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_be_q    <= 4'd0;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      off_q       <= off_d;
      out_val_q   <= out_val_d;
      exception_q <= exception_d;
      stall_q     <= stall_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out_val   = out_val_q;
  assign exception = exception_q;
  assign stall     = stall_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule
